// File: rtl/fifo_ctrl.sv
// Pointer/occupancy/flag controller for a first-word-fall-through FIFO built
// around an external reg_file array (write address, read address, write enable).
module fifo_ctrl #(
    parameter int ADDR_WIDTH = 2,
    parameter int AF_THRESH  = 3,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  clr_err,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] AF    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE    = (ADDR_WIDTH+1)'(AE_THRESH);

    logic [ADDR_WIDTH-1:0] w_ptr_reg, w_ptr_next;
    logic [ADDR_WIDTH-1:0] r_ptr_reg, r_ptr_next;
    logic [ADDR_WIDTH:0]   count_reg, count_next;
    logic                  overflow_reg, overflow_next;
    logic                  underflow_reg, underflow_next;
    logic                  do_wr, do_rd;

    // Status comes from registered state only, never from this cycle's requests.
    assign full         = (count_reg == DEPTH);
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= AF);
    assign almost_empty = (count_reg <= AE);
    assign count        = count_reg;
    assign w_addr       = w_ptr_reg;
    assign r_addr       = r_ptr_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // A simultaneous pop frees the slot, so a write into a full FIFO is legal
    // when rd is also high; an empty FIFO never bypasses the write to the read.
    assign do_wr = wr & (~full | rd);
    assign do_rd = rd & ~empty;
    assign wr_en = do_wr & ~reset;

    always_comb begin
        w_ptr_next     = w_ptr_reg + ADDR_WIDTH'(do_wr);
        r_ptr_next     = r_ptr_reg + ADDR_WIDTH'(do_rd);
        count_next     = count_reg + (ADDR_WIDTH+1)'(do_wr) - (ADDR_WIDTH+1)'(do_rd);
        overflow_next  = (wr & full & ~rd) | (overflow_reg & ~clr_err);
        underflow_next = (rd & empty) | (underflow_reg & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr_reg     <= '0;
            r_ptr_reg     <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            w_ptr_reg     <= w_ptr_next;
            r_ptr_reg     <= r_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed scenarios then random traffic,
// compared against a queue-based FIFO model; a second instance covers AF=2/AE=0.
module tb_fifo_ctrl;

    localparam int AW = 2;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset, wr, rd, clr_err;
    logic [7:0]    wdata;
    logic          wr_en, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [AW-1:0] w_addr, r_addr;
    logic [AW:0]   count;
    logic          wr_en2, full2, empty2, af2, ae2, ovf2, unf2;
    logic [AW-1:0] w_addr2, r_addr2;
    logic [AW:0]   count2;

    logic [7:0]    mem [D];

    int            total  = 0;
    int            passed = 0;
    bit [7:0]      q[$];
    bit            m_ovf, m_unf;
    int            wr_cnt, rd_cnt;

    always #5 clk = ~clk;

    fifo_ctrl #(.ADDR_WIDTH(AW), .AF_THRESH(3), .AE_THRESH(1)) dut (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .clr_err(clr_err),
        .wr_en(wr_en), .w_addr(w_addr), .r_addr(r_addr), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    fifo_ctrl #(.ADDR_WIDTH(AW), .AF_THRESH(2), .AE_THRESH(0)) dut2 (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .clr_err(clr_err),
        .wr_en(wr_en2), .w_addr(w_addr2), .r_addr(r_addr2), .full(full2), .empty(empty2),
        .almost_full(af2), .almost_empty(ae2), .count(count2),
        .overflow(ovf2), .underflow(unf2)
    );

    // Stand-in for the paired reg_file array.
    always @(posedge clk) if (wr_en) mem[w_addr] <= wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle: drive inputs, check outputs before the edge, update the model.
    task automatic step(input bit w, input bit r, input bit c, input bit rs, input bit [7:0] d);
        int  n;
        bit  acc_wr, acc_rd, was_full, was_empty;
        wr = w; rd = r; clr_err = c; reset = rs; wdata = d;
        #1;
        n         = q.size();
        was_full  = (n == D);
        was_empty = (n == 0);
        acc_wr    = !rs && w && (!was_full || r);
        acc_rd    = !rs && r && !was_empty;
        chk("count", 32'(count), 32'(n));
        chk("empty", 32'(empty), 32'(was_empty));
        chk("full", 32'(full), 32'(was_full));
        chk("almost_full", 32'(almost_full), 32'(n >= 3));
        chk("almost_empty", 32'(almost_empty), 32'(n <= 1));
        chk("af2", 32'(af2), 32'(n >= 2));
        chk("ae2", 32'(ae2), 32'(n <= 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        chk("w_addr", 32'(w_addr), 32'(wr_cnt % D));
        chk("r_addr", 32'(r_addr), 32'(rd_cnt % D));
        chk("wr_en", 32'(wr_en), 32'(acc_wr));
        if (n > 0) chk("head", 32'(mem[r_addr]), 32'(q[0]));
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_ovf = 0; m_unf = 0; wr_cnt = 0; rd_cnt = 0;
        end else begin
            if (acc_rd) begin void'(q.pop_front()); rd_cnt++; end
            if (acc_wr) begin q.push_back(d); wr_cnt++; end
            m_ovf = (w && was_full && !r) || (m_ovf && !c);
            m_unf = (r && was_empty) || (m_unf && !c);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; wdata = 8'h00;
        @(posedge clk);
        @(negedge clk);
        q.delete(); m_ovf = 0; m_unf = 0; wr_cnt = 0; rd_cnt = 0;

        // Fill, overflow attempt, clear, drain
        step(0, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'hA1);
        step(1, 0, 0, 0, 8'hA2);
        step(1, 0, 0, 0, 8'hA3);
        step(1, 0, 0, 0, 8'hA4);
        step(1, 0, 0, 0, 8'hEE);
        step(0, 0, 1, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        // Simultaneous ops on full, then drain
        step(1, 1, 0, 0, 8'hB5);
        step(0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        // Simultaneous ops on empty
        step(1, 1, 0, 0, 8'hC0);
        step(0, 0, 0, 0, 8'h00);
        step(0, 1, 1, 0, 8'h00);
        // Pointer wrap with alternating write/read
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 8'(8'h10 + i));
            step(0, 1, 0, 0, 8'h00);
        end
        // Reset mid-stream concurrent with a write
        step(1, 0, 0, 0, 8'h31);
        step(1, 0, 0, 0, 8'h32);
        step(1, 0, 0, 0, 8'h33);
        step(1, 0, 0, 1, 8'h34);
        step(1, 0, 0, 0, 8'hD7);
        step(0, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(bit'($urandom_range(0, 99) < 55), bit'($urandom_range(0, 99) < 50),
                 bit'($urandom_range(0, 99) < 10), bit'($urandom_range(0, 99) < 2),
                 8'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer/flag controller that drives the write and read sides of the `reg_file` storage array. Together the two blocks form a synchronous first-word-fall-through FIFO.
- The block generates `w_addr`, `r_addr` and `wr_en` for the array, and tracks occupancy.
- It reports full, empty, almost-full and almost-empty status, plus sticky overflow/underflow error flags, to producer and consumer logic in the same clock domain.

Parameters:
- ADDR_WIDTH, 2: number of address bits; depth D = 2**ADDR_WIDTH; must match the paired `reg_file`.
- AF_THRESH, 3: almost_full asserts when count >= AF_THRESH; legal range 1..D.
- AE_THRESH, 1: almost_empty asserts when count <= AE_THRESH; legal range 0..D-1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- wr  input  1  producer write request; data is presented to the array in the same cycle.
- rd  input  1  consumer read/pop request; head word is valid on the array's r_data while empty=0.
- clr_err  input  1  clears the sticky overflow and underflow flags.
- wr_en  output  1  write enable to the array; equals wr & accepted-write (combinational).
- w_addr  output  ADDR_WIDTH  write pointer to the array.
- r_addr  output  ADDR_WIDTH  read pointer to the array (head of queue).
- full  output  1  count == D.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  ADDR_WIDTH+1  current occupancy, 0..D.
- overflow  output  1  sticky: a write was refused because the FIFO was full.
- underflow  output  1  sticky: a read was refused because the FIFO was empty.

Behaviour:
- Reset (synchronous, reset=1 at a clock edge):
  - w_ptr=0, r_ptr=0, count=0, overflow=0, underflow=0.
  - Consequent outputs: empty=1, full=0, almost_empty=1 (since AE_THRESH>=0), almost_full=0.
  - wr_en=0 while reset is high, regardless of wr.
  - Reset overrides every simultaneous request. A reset mid-stream discards contents; array data is not cleared, but is unreachable.
- Flag and address outputs are derived combinationally from registered state only; they never depend on the current wr/rd.
- Accept rules, evaluated each cycle from state at the start of the cycle:
  - do_wr = wr & (~full | rd).
  - do_rd = rd & ~empty.
  - Full with wr & rd: both are accepted. The pop frees the slot and the write lands in the vacated location, which is w_ptr == r_ptr.
  - Empty with wr & rd: only the write is accepted; the read is refused and sets underflow. No bypass.
- wr_en = do_wr. The array latches w_data at w_addr on the same edge.
- Pointer update on each edge:
  - w_ptr += do_wr, modulo D (D-1 wraps to 0).
  - r_ptr += do_rd, modulo D.
- Count update: count + do_wr - do_rd. It never exceeds D and never goes below 0.
- Read latency: zero. A word written at edge N is visible on r_data after edge N once empty=0. rd pops it at the next edge where rd=1.
- Error flags:
  - overflow sets at an edge where wr & full & ~rd.
  - underflow sets at an edge where rd & empty.
  - Both hold until clr_err=1 or reset.
  - If clr_err and a new error occur at the same edge, set wins and the flag remains 1.
- Refused requests change no pointer or count.

Test Plan:
- Fill/drain, ADDR_WIDTH=2:
  - Reset, then write 0xA1..0xA4 over 4 cycles -> count 1,2,3,4; full=1 after the 4th write; w_addr wraps to 0; almost_full=1 from count 3.
  - Then rd 4 cycles -> r_data sequence 0xA1,0xA2,0xA3,0xA4; empty=1 after the last pop; count=0.
- Overflow: with the FIFO full (count=4), wr=1, rd=0 -> wr_en=0; count stays 4; overflow=1 next cycle.
  - Pulse clr_err -> overflow=0.
  - Then 0xA1 is still the head.
- Simultaneous ops:
  - Full: wr=1 with 0xB5, rd=1 -> wr_en=1; count stays 4; head advances; 0xB5 is read last.
  - Empty: wr=1 with 0xC0, rd=1 -> count=1; underflow=1; r_data=0xC0 next cycle.
- Pointer wrap: alternate single write/read for 10 cycles -> count toggles 1/0; r_addr and w_addr cycle 0,1,2,3,0,...; data order is preserved.
- Reset mid-operation: after 3 writes, assert reset for 1 cycle concurrently with wr=1 -> count=0, empty=1, wr_en=0, w_addr=r_addr=0.
  - The next write (0xD7) is the first word read.
- Thresholds: with AF_THRESH=2 and AE_THRESH=0, write 2 words -> almost_empty drops after the 1st write; almost_full asserts after the 2nd write.
